// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared core definitions: debug FSM states and pipeline-register control bundle
package CoreDefs;

    // Debug halt/step controller states.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2,
        STEP      = 2'd3
    } PipeCtrlState;

    // Control pair for a single pipeline register; stall wins over flush.
    typedef struct packed {
        logic stall;
        logic flush;
    } StageCtl;

    // Controls for every pipeline register, so the top level wires them as one bundle.
    typedef struct packed {
        StageCtl ifid;
        StageCtl idex;
        StageCtl exmem;
        StageCtl memwb;
    } PipeCtrl;

    localparam PipeCtrl PIPE_IDLE = '0;

    // Every register holds and nothing is squashed.
    localparam PipeCtrl PIPE_HOLD = '{
        ifid:  '{stall: 1'b1, flush: 1'b0},
        idex:  '{stall: 1'b1, flush: 1'b0},
        exmem: '{stall: 1'b1, flush: 1'b0},
        memwb: '{stall: 1'b1, flush: 1'b0}
    };

endpackage

// File: rtl/pipeline_tick_counter.sv
// rtl/pipeline_tick_counter.sv - free-running wrapping tick counter
// Ports:
//   clk_i    core clock
//   rst_ni   asynchronous active-low reset, clears the count
//   count_o  current tick, increments every rising edge and wraps to 0
module pipeline_tick_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Natural modulo-2^WIDTH overflow provides the wrap from all-ones to 0.
    assign count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush priority decode, debug halt/step FSM and debug tick source
// Ports:
//   i_clock, i_reset                core clock, asynchronous active-low reset
//   i_ifBusy, i_memBusy             fetch / data-memory not ready
//   i_loadUse, i_branchTaken        load-use hazard in ID, taken branch resolved in EX
//   i_dbgHalt, i_dbgStep            debug halt level, single-step pulse
//   o_pcStall                       hold the PC
//   o_stall*/o_flush*               per pipeline register control (combinational)
//   o_dbgTick                       tick number of the current cycle
//   o_halted                        core is in HALTED
module pipeline_hazard_ctrl
    import CoreDefs::*;
#(
    parameter int TICK_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ifBusy,
    input  logic                  i_memBusy,
    input  logic                  i_loadUse,
    input  logic                  i_branchTaken,
    input  logic                  i_dbgHalt,
    input  logic                  i_dbgStep,
    output logic                  o_pcStall,
    output logic                  o_stallIFID,
    output logic                  o_flushIFID,
    output logic                  o_stallIDEX,
    output logic                  o_flushIDEX,
    output logic                  o_stallEXMEM,
    output logic                  o_flushEXMEM,
    output logic                  o_stallMEMWB,
    output logic                  o_flushMEMWB,
    output logic [TICK_WIDTH-1:0] o_dbgTick,
    output logic                  o_halted
);

    PipeCtrlState state_q;
    PipeCtrlState state_d;
    logic         halted_q;
    logic         pc_stall;
    PipeCtrl      ctl;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (i_dbgHalt) begin
                    state_d = i_memBusy ? HALT_PEND : HALTED;
                end
            end
            HALT_PEND: begin
                // A dropped halt request wins over the memory going idle.
                if (!i_dbgHalt) begin
                    state_d = RUN;
                end else if (!i_memBusy) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (i_dbgStep) begin
                    state_d = STEP;
                end else if (!i_dbgHalt) begin
                    state_d = RUN;
                end
            end
            STEP: begin
                // Wait out a memory stall so exactly one instruction advances.
                if (!i_memBusy) begin
                    state_d = i_dbgHalt ? HALTED : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Hazard priority decode; HALT_PEND and STEP decode exactly like RUN.
    always_comb begin
        pc_stall = 1'b0;
        ctl      = PIPE_IDLE;
        if ((state_q == HALTED) || i_memBusy) begin
            pc_stall = 1'b1;
            ctl      = PIPE_HOLD;
        end else if (i_branchTaken) begin
            // Wrong-path instructions are squashed, so their hazards are moot.
            ctl.ifid.flush = 1'b1;
            ctl.idex.flush = 1'b1;
        end else if (i_loadUse) begin
            // Hold IF/ID (keeping any valid fetch) and inject a bubble into EX.
            pc_stall       = 1'b1;
            ctl.ifid.stall = 1'b1;
            ctl.idex.flush = 1'b1;
        end else if (i_ifBusy) begin
            pc_stall       = 1'b1;
            ctl.ifid.flush = 1'b1;
        end
    end

    pipeline_tick_counter #(
        .WIDTH (TICK_WIDTH)
    ) u_tick (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .count_o (o_dbgTick)
    );

    assign o_pcStall    = pc_stall;
    assign o_stallIFID  = ctl.ifid.stall;
    assign o_flushIFID  = ctl.ifid.flush;
    assign o_stallIDEX  = ctl.idex.stall;
    assign o_flushIDEX  = ctl.idex.flush;
    assign o_stallEXMEM = ctl.exmem.stall;
    assign o_flushEXMEM = ctl.exmem.flush;
    assign o_stallMEMWB = ctl.memwb.stall;
    assign o_flushMEMWB = ctl.memwb.flush;
    assign o_halted     = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_busy = 1'b0, mem_busy = 1'b0, load_use = 1'b0, branch = 1'b0;
    logic dbg_halt = 1'b0, dbg_step = 1'b0;

    logic        pc_stall, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, s_memwb, f_memwb;
    logic [31:0] tick;
    logic        halted;

    logic        n_pc_stall, n_s_ifid, n_f_ifid, n_s_idex, n_f_idex, n_s_exmem, n_f_exmem, n_s_memwb, n_f_memwb;
    logic [3:0]  n_tick;
    logic        n_halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the core is either halted, stepping, or running
    // (a pending halt is indistinguishable from running at the outputs).
    bit          m_halted = 1'b0;
    bit          m_stepping = 1'b0;
    int unsigned m_tick = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TICK_WIDTH(32)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_ifBusy(if_busy), .i_memBusy(mem_busy), .i_loadUse(load_use),
        .i_branchTaken(branch), .i_dbgHalt(dbg_halt), .i_dbgStep(dbg_step),
        .o_pcStall(pc_stall),
        .o_stallIFID(s_ifid), .o_flushIFID(f_ifid),
        .o_stallIDEX(s_idex), .o_flushIDEX(f_idex),
        .o_stallEXMEM(s_exmem), .o_flushEXMEM(f_exmem),
        .o_stallMEMWB(s_memwb), .o_flushMEMWB(f_memwb),
        .o_dbgTick(tick), .o_halted(halted)
    );

    pipeline_hazard_ctrl #(.TICK_WIDTH(4)) dut_n (
        .i_clock(clk), .i_reset(rst_n),
        .i_ifBusy(if_busy), .i_memBusy(mem_busy), .i_loadUse(load_use),
        .i_branchTaken(branch), .i_dbgHalt(dbg_halt), .i_dbgStep(dbg_step),
        .o_pcStall(n_pc_stall),
        .o_stallIFID(n_s_ifid), .o_flushIFID(n_f_ifid),
        .o_stallIDEX(n_s_idex), .o_flushIDEX(n_f_idex),
        .o_stallEXMEM(n_s_exmem), .o_flushEXMEM(n_f_exmem),
        .o_stallMEMWB(n_s_memwb), .o_flushMEMWB(n_f_memwb),
        .o_dbgTick(n_tick), .o_halted(n_halted)
    );

    // {pcStall, stallIFID, flushIFID, stallIDEX, flushIDEX, stallEXMEM, flushEXMEM, stallMEMWB, flushMEMWB}
    function automatic logic [8:0] expect_ctl(bit hold, bit br, bit lu, bit ifb);
        if (hold)     return 9'b1_10_10_10_10;
        else if (br)  return 9'b0_01_01_00_00;
        else if (lu)  return 9'b1_10_01_00_00;
        else if (ifb) return 9'b1_01_00_00_00;
        else          return 9'b0_00_00_00_00;
    endfunction

    function automatic logic [8:0] dut_ctl();
        return {pc_stall, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, s_memwb, f_memwb};
    endfunction

    function automatic logic [8:0] dutn_ctl();
        return {n_pc_stall, n_s_ifid, n_f_ifid, n_s_idex, n_f_idex, n_s_exmem, n_f_exmem, n_s_memwb, n_f_memwb};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halted   = 1'b0;
            m_stepping = 1'b0;
            m_tick     = 0;
        end else begin
            m_tick = m_tick + 1;
            if (m_halted) begin
                if (dbg_step) begin
                    m_halted   = 1'b0;
                    m_stepping = 1'b1;
                end else if (!dbg_halt) begin
                    m_halted = 1'b0;
                end
            end else if (m_stepping) begin
                if (!mem_busy) begin
                    m_stepping = 1'b0;
                    m_halted   = dbg_halt;
                end
            end else if (dbg_halt && !mem_busy) begin
                m_halted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp;
        exp = expect_ctl(m_halted || mem_busy, branch, load_use, if_busy);
        check("model_ctl", {23'd0, dut_ctl()}, {23'd0, exp});
        check("model_ctl_narrow", {23'd0, dutn_ctl()}, {23'd0, exp});
        check("model_halted", {31'd0, halted}, {31'd0, m_halted});
        check("model_tick", tick, m_tick);
        check("model_tick_narrow", {28'd0, n_tick}, {28'd0, m_tick[3:0]});
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {memBusy, branchTaken, loadUse, ifBusy}
    logic [3:0] vecs [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111,
                              4'b1000, 4'b1111, 4'b0101, 4'b0110, 4'b1010, 4'b0000};

    initial begin
        cyc(2);
        rst_n = 1'b1;

        cyc(5);
        check("tick_after_5", tick, 32'd5);
        check("idle_ctl", {23'd0, dut_ctl()}, 32'd0);
        check("idle_halted", {31'd0, halted}, 32'd0);

        cyc(12);
        check("narrow_tick_wrap", {28'd0, n_tick}, 32'd1);

        load_use = 1'b1;
        #1 check("load_use_ctl", {23'd0, dut_ctl()}, {23'd0, 9'b1_10_01_00_00});
        cyc();
        load_use = 1'b0;
        #1 check("after_load_use", {23'd0, dut_ctl()}, 32'd0);

        branch = 1'b1; load_use = 1'b1; if_busy = 1'b1;
        #1 check("branch_wins", {23'd0, dut_ctl()}, {23'd0, 9'b0_01_01_00_00});
        branch = 1'b0;
        #1 check("load_use_over_ifbusy", {23'd0, dut_ctl()}, {23'd0, 9'b1_10_01_00_00});
        load_use = 1'b0; if_busy = 1'b0;

        cyc();
        mem_busy = 1'b1; dbg_halt = 1'b1;
        cyc(3);
        check("halt_pend_not_halted", {31'd0, halted}, 32'd0);
        mem_busy = 1'b0;
        #1 check("halt_pend_runs", {23'd0, dut_ctl()}, 32'd0);
        cyc();
        check("halted_set", {31'd0, halted}, 32'd1);
        check("halted_stall", {23'd0, dut_ctl()}, {23'd0, 9'b1_10_10_10_10});

        dbg_step = 1'b1;
        cyc();
        dbg_step = 1'b0;
        check("step_open", {23'd0, dut_ctl()}, 32'd0);
        check("step_not_halted", {31'd0, halted}, 32'd0);
        cyc();
        check("step_back_halted", {31'd0, halted}, 32'd1);

        mem_busy = 1'b1; dbg_step = 1'b1;
        cyc();
        dbg_step = 1'b0;
        cyc(2);
        check("step_waits_mem", {31'd0, halted}, 32'd0);
        mem_busy = 1'b0;
        cyc();
        check("step_done_mem", {31'd0, halted}, 32'd1);

        dbg_halt = 1'b0;
        cyc();
        check("resume_run", {31'd0, halted}, 32'd0);

        dbg_halt = 1'b1;
        cyc();
        dbg_step = 1'b1;
        cyc();
        dbg_step = 1'b0; dbg_halt = 1'b0; mem_busy = 1'b1;
        #2 rst_n = 1'b0;
        mem_busy = 1'b0;
        #1;
        check("async_tick_clear", tick, 32'd0);
        check("async_narrow_clear", {28'd0, n_tick}, 32'd0);
        check("async_halted_clear", {31'd0, halted}, 32'd0);
        check("async_fsm_run", {23'd0, dut_ctl()}, 32'd0);
        cyc();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            {mem_busy, branch, load_use, if_busy} = vecs[i];
            dbg_halt = (i >= 6) && (i < 9);
            cyc();
        end
        {mem_busy, branch, load_use, if_busy, dbg_halt} = '0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It combines the hazard requests from all stages into the per-register `stall`/`flush` pair consumed by every pipeline register, including the debug pipeline registers. It also runs the debug halt/step state machine and supplies the free-running tick number injected into the debug pipeline at IF.

## Interface
Parameters:
- `TICK_WIDTH`, default 32: width of the tick counter (matches `int`).

Ports:
- `i_clock`  in  1  core clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_ifBusy`  in  1  instruction fetch not ready this cycle.
- `i_memBusy`  in  1  data memory access not complete; the whole pipeline must hold.
- `i_loadUse`  in  1  the instruction in ID needs a load result still in EX.
- `i_branchTaken`  in  1  EX resolved a taken branch or jump; the PC is redirected.
- `i_dbgHalt`  in  1  debug halt request (level).
- `i_dbgStep`  in  1  single-step request (pulse, honoured only in HALTED).
- `o_pcStall`  out  1  hold the PC.
- `o_stallIFID`, `o_flushIFID`  out  1 each  control for the IF/ID register.
- `o_stallIDEX`, `o_flushIDEX`  out  1 each  control for the ID/EX register.
- `o_stallEXMEM`, `o_flushEXMEM`  out  1 each  control for the EX/MEM register.
- `o_stallMEMWB`, `o_flushMEMWB`  out  1 each  control for the MEM/WB register.
- `o_dbgTick`  out  TICK_WIDTH  current tick number, fed to the IF debug register.
- `o_halted`  out  1  the core is in the HALTED state.

## Operation
- Stall has priority over flush at every register. This controller never asserts both on the same register in the same cycle.
- Stall and flush outputs are combinational from the inputs and the FSM state; there is no added latency.
- Request priority in RUN or STEP, highest first:
  1. Halt condition (HALTED state): `o_pcStall` and all four stall outputs are 1; all flush outputs are 0.
  2. `i_memBusy`: `o_pcStall` and all four stall outputs are 1. Branch, load-use and fetch requests are ignored this cycle.
  3. `i_branchTaken`: `o_flushIFID` = 1 and `o_flushIDEX` = 1. The PC is not stalled and the redirect is loaded. Any load-use or fetch request is ignored, because the instructions involved are squashed.
  4. `i_loadUse`: `o_pcStall` = 1, `o_stallIFID` = 1, `o_flushIDEX` = 1 (a bubble is inserted).
  5. `i_ifBusy`: `o_pcStall` = 1, `o_flushIFID` = 1 (a bubble enters ID).
  6. None of the above: all outputs are 0.
- `i_loadUse` and `i_ifBusy` together: rule 4 applies, and IF/ID keeps its valid instruction.
- Debug FSM states (`PipeCtrlState`): RUN, HALT_PEND, HALTED, STEP.
  - RUN → HALTED when `i_dbgHalt` is set and `i_memBusy` is clear.
  - RUN → HALT_PEND when `i_dbgHalt` is set and `i_memBusy` is set.
  - HALT_PEND behaves as RUN. It moves to HALTED on the first cycle with `i_memBusy` clear. If `i_dbgHalt` drops first, it returns to RUN.
  - HALTED → STEP when `i_dbgStep` is set. HALTED → RUN when `i_dbgHalt` is clear. If both apply, step takes priority.
  - STEP behaves as RUN for exactly one clock, then returns to HALTED if `i_dbgHalt` is still set, otherwise to RUN. If `i_memBusy` is set during STEP, the FSM stays in STEP until the cycle in which it is clear, so that one instruction actually advances.
- `o_halted` is 1 only in HALTED (a registered decode of the state).
- Tick counter:
  - Increments on every clock edge, in every state.
  - Wraps from all-ones to 0.
  - The value shown at `o_dbgTick` is the tick of the current cycle.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - FSM to RUN;
  - tick counter to 0;
  - `o_halted` to 0;
  - stall/flush outputs to their combinational values for RUN.
- First rising edge after reset release: `o_dbgTick` goes 0 → 1.
- Halt latency: `i_dbgHalt` set at edge N with memory idle gives `o_halted` = 1 and a full stall from cycle N+1.
- Reset asserted mid-STEP or mid-HALT_PEND: the FSM returns to RUN immediately, with no step completed.

## Structure
- Add `PipeCtrlState` (enum, 2 bits) to the shared package `CoreDefs`.
- Add a `PipeCtrl` struct there as well, holding `{stall, flush}` per register, so the top level can wire stage controls as one bundle.
- Sub-module `pipeline_tick_counter`: a parameterised wrapping counter with asynchronous active-low reset.
- The FSM and the priority decode stay in this module.

## Test plan
- Reset released, no requests, 5 clocks → all stall/flush outputs 0; `o_dbgTick` reads 5; `o_halted` = 0.
- `i_loadUse` = 1 for one cycle → `o_pcStall` = 1, `o_stallIFID` = 1, `o_flushIDEX` = 1 that cycle; all outputs 0 on the next cycle.
- `i_branchTaken` = 1 together with `i_loadUse` = 1 and `i_ifBusy` = 1 → only `o_flushIFID` = 1 and `o_flushIDEX` = 1; `o_pcStall` = 0.
- `i_memBusy` high for 3 cycles with `i_dbgHalt` raised in the first of them → HALT_PEND for 3 cycles, then `o_halted` = 1 with all stalls at 1.
- In HALTED, one-cycle `i_dbgStep` pulse → one cycle with all outputs 0 (STEP), then back to HALTED; a step pulse held during `i_memBusy` = 1 waits until the memory is idle.
- `TICK_WIDTH` = 4, 17 clocks after reset → `o_dbgTick` reads 1 (wrap-around); async reset asserted mid-cycle → counter and FSM cleared without waiting for a clock edge.
